alu_wb_regs: RTL and testbench

Writeback and operand-storage stage for the 8-bit datapath. It consumes the ALU result `y` and `zero` flag, holds them for one cycle in a writeback register, and then commits them to a register file. The register file has 16 entries; R0 is hardwired to zero. Two combinational read ports with bypass supply the ALU `a`/`b` operands, and a registered zero flag is kept for branch logic.

---
 rtl/alu_wb_regs.sv | 87 ++++++++
 tb/tb_alu_wb_regs.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/alu_wb_regs.sv
// rtl/alu_wb_regs.sv - writeback register, 16-entry register file with bypass reads, zero flag
module alu_wb_regs #(
   parameter int WIDTH = 8,
   parameter int NREG  = 16,
   localparam int AW   = $clog2(NREG)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ex_valid,
   input  logic             ex_we,
   input  logic             ex_flag_we,
   input  logic [AW-1:0]    ex_wa,
   input  logic [WIDTH-1:0] y,
   input  logic             zero,
   input  logic [AW-1:0]    ra1,
   input  logic [AW-1:0]    ra2,
   output logic [WIDTH-1:0] rd1,
   output logic [WIDTH-1:0] rd2,
   output logic             zflag,
   output logic             wb_pending
);

   logic [WIDTH-1:0] regs_q [NREG];
   logic [WIDTH-1:0] regs_d [NREG];
   logic             wb_valid_q, wb_valid_d;
   logic [AW-1:0]    wb_wa_q, wb_wa_d;
   logic [WIDTH-1:0] wb_data_q, wb_data_d;
   logic             zflag_q, zflag_d;

   // Next state: commit the held write, capture the new one (R0 writes dropped), update flag
   always_comb begin
      regs_d = regs_q;
      if (wb_valid_q) begin
         regs_d[wb_wa_q] = wb_data_q;
      end
      regs_d[0]  = '0;
      wb_valid_d = ex_valid & ex_we & (ex_wa != '0);
      wb_wa_d    = ex_wa;
      wb_data_d  = y;
      zflag_d    = (ex_valid & ex_flag_we) ? zero : zflag_q;
   end

   // State registers; reset discards any pending write rather than committing it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
         wb_valid_q <= 1'b0;
         wb_wa_q    <= '0;
         wb_data_q  <= '0;
         zflag_q    <= 1'b0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= regs_d[i];
         end
         wb_valid_q <= wb_valid_d;
         wb_wa_q    <= wb_wa_d;
         wb_data_q  <= wb_data_d;
         zflag_q    <= zflag_d;
      end
   end

   // Read ports: R0 is zero, then the not-yet-committed write, then the array
   always_comb begin
      rd1 = '0;
      rd2 = '0;
      if (ra1 == '0) begin
         rd1 = '0;
      end else if (wb_valid_q && (wb_wa_q == ra1)) begin
         rd1 = wb_data_q;
      end else begin
         rd1 = regs_q[ra1];
      end
      if (ra2 == '0) begin
         rd2 = '0;
      end else if (wb_valid_q && (wb_wa_q == ra2)) begin
         rd2 = wb_data_q;
      end else begin
         rd2 = regs_q[ra2];
      end
   end

   assign zflag      = zflag_q;
   assign wb_pending = wb_valid_q;

endmodule

// File: tb/tb_alu_wb_regs.sv
// tb/tb_alu_wb_regs.sv - self-checking bench for alu_wb_regs
module tb_alu_wb_regs;

   logic       clk = 1'b0;
   logic       reset;
   logic       ex_valid, ex_we, ex_flag_we, zero;
   logic [3:0] ex_wa, ra1, ra2;
   logic [7:0] y, rd1, rd2;
   logic       zflag, wb_pending;

   int checks = 0;
   int errors = 0;

   // Architectural model: a write is readable from the cycle after it is presented
   logic [7:0] m_regs [16];
   logic       m_pend;
   logic       m_z;

   alu_wb_regs dut (
      .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_we(ex_we),
      .ex_flag_we(ex_flag_we), .ex_wa(ex_wa), .y(y), .zero(zero),
      .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2), .zflag(zflag),
      .wb_pending(wb_pending)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       v, we, fwe;
      logic [3:0] wa;
      logic [7:0] yv;
      logic       zr;
      logic [3:0] a1, a2;
      logic [7:0] e1, e2;
      logic       ez, ep;
   } vec_t;

   vec_t tbl [15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
      m_pend = 1'b0;
      m_z    = 1'b0;
   endtask

   function automatic logic [7:0] m_read(input logic [3:0] a);
      return (a == 4'd0) ? 8'h00 : m_regs[a];
   endfunction

   // Clock edge: model absorbs the inputs present at the edge, then inputs may change
   task automatic tick();
      @(posedge clk);
      m_pend = ex_valid && ex_we && (ex_wa != 4'd0);
      if (m_pend) m_regs[ex_wa] = y;
      if (ex_valid && ex_flag_we) m_z = zero;
      #1;
   endtask

   task automatic set_in(input logic v, input logic we, input logic fwe, input logic [3:0] wa,
                         input logic [7:0] yv, input logic zr, input logic [3:0] a1, input logic [3:0] a2);
      ex_valid = v; ex_we = we; ex_flag_we = fwe; ex_wa = wa; y = yv; zero = zr; ra1 = a1; ra2 = a2;
   endtask

   task automatic chk_model(input string tag);
      chk({tag, "_rd1"}, rd1, m_read(ra1));
      chk({tag, "_rd2"}, rd2, m_read(ra2));
      chk({tag, "_zflag"}, zflag, m_z);
      chk({tag, "_pend"}, wb_pending, m_pend);
   endtask

   initial begin
      //           v    we   fwe  wa     y      zr   ra1    ra2    rd1    rd2    z    pend
      tbl[0]  = {1'b1,1'b1,1'b0,4'd3, 8'hA5,1'b0,4'd3, 4'd7, 8'h00,8'h00,1'b0,1'b0};
      tbl[1]  = {1'b1,1'b1,1'b0,4'd7, 8'h11,1'b0,4'd3, 4'd7, 8'hA5,8'h00,1'b0,1'b1};
      tbl[2]  = {1'b1,1'b1,1'b0,4'd7, 8'h22,1'b0,4'd3, 4'd7, 8'hA5,8'h11,1'b0,1'b1};
      tbl[3]  = {1'b0,1'b0,1'b0,4'd0, 8'h00,1'b0,4'd3, 4'd7, 8'hA5,8'h22,1'b0,1'b1};
      tbl[4]  = {1'b0,1'b0,1'b0,4'd0, 8'h00,1'b0,4'd7, 4'd7, 8'h22,8'h22,1'b0,1'b0};
      tbl[5]  = {1'b1,1'b1,1'b0,4'd0, 8'hFF,1'b0,4'd0, 4'd1, 8'h00,8'h00,1'b0,1'b0};
      tbl[6]  = {1'b0,1'b0,1'b0,4'd0, 8'h00,1'b0,4'd0, 4'd1, 8'h00,8'h00,1'b0,1'b0};
      tbl[7]  = {1'b1,1'b0,1'b1,4'd3, 8'h00,1'b1,4'd3, 4'd0, 8'hA5,8'h00,1'b0,1'b0};
      tbl[8]  = {1'b0,1'b1,1'b1,4'd3, 8'h00,1'b0,4'd3, 4'd7, 8'hA5,8'h22,1'b1,1'b0};
      tbl[9]  = {1'b1,1'b0,1'b1,4'd3, 8'h00,1'b0,4'd3, 4'd7, 8'hA5,8'h22,1'b1,1'b0};
      tbl[10] = {1'b1,1'b1,1'b0,4'd2, 8'h0F,1'b0,4'd3, 4'd2, 8'hA5,8'h00,1'b0,1'b0};
      tbl[11] = {1'b0,1'b0,1'b0,4'd0, 8'h00,1'b0,4'd2, 4'd2, 8'h0F,8'h0F,1'b0,1'b1};
      tbl[12] = {1'b1,1'b1,1'b0,4'd9, 8'hF0,1'b0,4'd2, 4'd9, 8'h0F,8'h00,1'b0,1'b0};
      tbl[13] = {1'b0,1'b0,1'b0,4'd0, 8'h00,1'b0,4'd2, 4'd9, 8'h0F,8'hF0,1'b0,1'b1};
      tbl[14] = {1'b0,1'b0,1'b0,4'd0, 8'h00,1'b0,4'd2, 4'd9, 8'h0F,8'hF0,1'b0,1'b0};

      reset = 1'b0;
      set_in(0, 0, 0, 4'd0, 8'h00, 0, 4'd1, 4'd2);
      model_clear();
      #2 reset = 1'b1;
      #1;
      chk("reset_rd1", rd1, 8'h00);
      chk("reset_rd2", rd2, 8'h00);
      chk("reset_zflag", zflag, 1'b0);
      chk("reset_pend", wb_pending, 1'b0);
      @(negedge clk) reset = 1'b0;
      @(posedge clk); #1;

      // Directed vector table
      for (int i = 0; i < 15; i++) begin
         set_in(tbl[i].v, tbl[i].we, tbl[i].fwe, tbl[i].wa, tbl[i].yv, tbl[i].zr, tbl[i].a1, tbl[i].a2);
         @(negedge clk);
         chk($sformatf("tbl%0d_rd1", i), rd1, tbl[i].e1);
         chk($sformatf("tbl%0d_rd2", i), rd2, tbl[i].e2);
         chk($sformatf("tbl%0d_zflag", i), zflag, tbl[i].ez);
         chk($sformatf("tbl%0d_pend", i), wb_pending, tbl[i].ep);
         tick();
      end

      // Asynchronous reset while R5 = 0x3C is pending and zflag is being set
      set_in(1, 1, 1, 4'd5, 8'h3C, 1, 4'd5, 4'd5);
      tick();
      set_in(0, 0, 0, 4'd0, 8'h00, 0, 4'd5, 4'd5);
      chk("pre_reset_pend", wb_pending, 1'b1);
      chk("pre_reset_bypass", rd1, 8'h3C);
      #1 reset = 1'b1;
      #1;
      chk("areset_zflag", zflag, 1'b0);
      chk("areset_pend", wb_pending, 1'b0);
      for (int a = 0; a < 16; a++) begin
         ra1 = 4'(a);
         ra2 = 4'(15 - a);
         #1;
         chk($sformatf("areset_rd1_r%0d", a), rd1, 8'h00);
         chk($sformatf("areset_rd2_r%0d", 15 - a), rd2, 8'h00);
      end
      model_clear();
      @(negedge clk) reset = 1'b0;
      ra1 = 4'd5; ra2 = 4'd3;
      tick();
      @(negedge clk);
      chk("post_reset_r5", rd1, 8'h00);
      chk("post_reset_r3", rd2, 8'h00);
      chk("post_reset_pend", wb_pending, 1'b0);
      tick();

      // Randomized traffic against the architectural model
      for (int n = 0; n < 400; n++) begin
         set_in(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom),
                8'($urandom), 1'($urandom),
                ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom),
                ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom));
         @(negedge clk);
         chk_model($sformatf("rnd%0d", n));
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
